// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, rcon arithmetic and key-schedule FSM encoding
package aes_pkg;

    localparam int         AES_NR        = 10;
    localparam logic [7:0] AES_RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
    } ks_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box, one byte in, one byte out
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - sequential AES-128 key expander, one round key per cycle, 11-slot store
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic [KW-1:0] key_in,
    output logic          busy,
    output logic          keys_ready,
    input  logic          rd_en,
    input  logic [3:0]    rd_idx,
    output logic          rd_valid,
    output logic [KW-1:0] rd_key
);

    localparam logic [3:0] LAST = 4'(NR);

    ks_state_e      state, state_nxt;
    logic [3:0]     round, last_wr, prev_idx;
    logic [7:0]     rcon;
    logic           wr_any, accept, rd_hit;
    logic [KW-1:0]  slots [0:NR];
    logic [31:0]    w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;

    assign key_ready = (state != ST_EXPAND);
    assign busy      = (state == ST_EXPAND);
    assign accept    = key_valid & key_ready;

    // Previous round key feeds the single shared SubWord datapath
    assign prev_idx         = (round == 4'd0) ? 4'd0 : round - 4'd1;
    assign {w0, w1, w2, w3} = slots[prev_idx];
    assign rot              = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .din  (rot[8*g +: 8]),
            .dout (sub[8*g +: 8])
        );
    end

    assign n0 = w0 ^ sub ^ {rcon, 24'h0};
    assign n1 = n0 ^ w1;
    assign n2 = n1 ^ w2;
    assign n3 = n2 ^ w3;

    // A slot becomes readable only after the edge that wrote it; no write-first bypass
    assign rd_hit = rd_en & wr_any & (rd_idx <= last_wr) & (rd_idx <= LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_READY: if (accept) state_nxt = ST_EXPAND;
            ST_EXPAND:         if (round == LAST) state_nxt = ST_READY;
            default:           state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            round      <= 4'd0;
            rcon       <= AES_RCON_INIT;
            last_wr    <= 4'd0;
            wr_any     <= 1'b0;
            keys_ready <= 1'b0;
            rd_valid   <= 1'b0;
            rd_key     <= '0;
            for (int i = 0; i <= NR; i++) slots[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                slots[0]   <= key_in;
                round      <= 4'd1;
                rcon       <= AES_RCON_INIT;
                last_wr    <= 4'd0;
                wr_any     <= 1'b1;
                keys_ready <= 1'b0;
            end else if (busy) begin
                slots[round] <= {n0, n1, n2, n3};
                last_wr      <= round;
                rcon         <= xtime(rcon);
                round        <= round + 4'd1;
                if (round == LAST) keys_ready <= 1'b1;
            end
            rd_valid <= rd_hit;
            rd_key   <= rd_hit ? slots[rd_idx] : '0;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - self-checking bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         keys_ready;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_idx = '0;
    logic         rd_valid;
    logic [127:0] rd_key;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_S1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_S10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_S1    = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_S10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic [7:0]   rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] exp_rk [0:10];
    logic         rv;
    logic [127:0] rk;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .busy       (busy),
        .keys_ready (keys_ready),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_valid   (rd_valid),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference S-box from first principles: GF(2^8) inverse followed by the affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0]  inv;
        logic [15:0] d;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        d = {inv, inv};
        return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])}
                    ^ {rcon_tab[i/4-1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Drivers: all start and end on a falling edge
    task automatic load_key(input logic [127:0] k);
        key_valid = 1'b1;
        key_in    = k;
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] idx);
        rd_en  = 1'b1;
        rd_idx = idx;
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        rv    = rd_valid;
        rk    = rd_key;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!keys_ready && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({key_ready, busy, keys_ready, rd_valid} !== 4'b1000 || rd_key !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/busy/kr/rv=%b key=%h expected 1000 key=0",
                     {key_ready, busy, keys_ready, rd_valid}, rd_key);
        end
        rst_n = 1'b1;
        @(negedge clk);
        do_read(4'd0);
        checks++;
        if (rv !== 1'b0 || rk !== '0) begin
            errors++;
            $display("FAIL reset_read: got valid=%b key=%h expected 0 0", rv, rk);
        end
    endtask

    task automatic test_fips_key;
        int n;
        model_expand(FIPS_KEY);
        load_key(FIPS_KEY);
        checks++;
        if (busy !== 1'b1 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL fips_busy: got busy=%b key_ready=%b expected 1 0", busy, key_ready);
        end
        wait_ready(n);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL fips_latency: got %0d edges expected 10", n);
        end
        for (int r = 0; r <= 10; r++) begin
            do_read(4'(r));
            checks++;
            if (rv !== 1'b1 || rk !== exp_rk[r]) begin
                errors++;
                $display("FAIL fips_slot%0d: got v=%b %h expected 1 %h", r, rv, rk, exp_rk[r]);
            end
            if (r == 1 || r == 10) begin
                checks++;
                if (rk !== ((r == 1) ? FIPS_S1 : FIPS_S10)) begin
                    errors++;
                    $display("FAIL fips_vector%0d: got %h expected %h", r, rk,
                             (r == 1) ? FIPS_S1 : FIPS_S10);
                end
            end
        end
    endtask

    task automatic test_rekey_zero;
        logic [127:0] old10;
        old10     = exp_rk[10];
        key_valid = 1'b1;
        key_in    = '0;
        rd_en     = 1'b1;
        rd_idx    = 4'd10;
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        rd_en     = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_key !== old10 || keys_ready !== 1'b0) begin
            errors++;
            $display("FAIL rekey_accept_read: got v=%b %h kr=%b expected 1 %h 0",
                     rd_valid, rd_key, keys_ready, old10);
        end
        model_expand('0);
        for (int k = 1; k <= 11; k++) begin
            do_read(4'd10);
            checks++;
            if (rv !== (k == 11) || rk !== ((k == 11) ? exp_rk[10] : '0) || keys_ready !== (k >= 10)) begin
                errors++;
                $display("FAIL rekey_edge%0d: got v=%b %h kr=%b expected %b kr=%b", k, rv, rk,
                         keys_ready, k == 11, k >= 10);
            end
        end
        for (int r = 0; r <= 10; r++) begin
            do_read(4'(r));
            checks++;
            if (rv !== 1'b1 || rk !== exp_rk[r]) begin
                errors++;
                $display("FAIL zero_slot%0d: got v=%b %h expected 1 %h", r, rv, rk, exp_rk[r]);
            end
        end
        do_read(4'd1);
        checks++;
        if (rk !== ZERO_S1) begin
            errors++;
            $display("FAIL zero_vector1: got %h expected %h", rk, ZERO_S1);
        end
        do_read(4'd10);
        checks++;
        if (rk !== ZERO_S10) begin
            errors++;
            $display("FAIL zero_vector10: got %h expected %h", rk, ZERO_S10);
        end
    endtask

    task automatic test_read_while_expanding;
        logic [127:0] k;
        logic [3:0]   idx;
        int           lw;
        logic         ev;
        k = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k);
        load_key(k);
        for (int e = 1; e <= 12; e++) begin
            idx = (e == 1) ? 4'd0 : (e == 4 || e == 6) ? 4'd5 : 4'($urandom_range(0, 11));
            lw  = (e - 1 > 10) ? 10 : e - 1;
            ev  = (int'(idx) <= lw);
            do_read(idx);
            checks++;
            if (rv !== ev || rk !== (ev ? exp_rk[idx] : '0)) begin
                errors++;
                $display("FAIL rwe_edge%0d_idx%0d: got v=%b %h expected %b %h", e, idx, rv, rk,
                         ev, ev ? exp_rk[idx] : '0);
            end
        end
    endtask

    task automatic test_ignore_valid;
        logic [127:0] a, b;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = ~a;
        model_expand(a);
        load_key(a);
        for (int e = 1; e <= 10; e++) begin
            key_valid = 1'($urandom_range(0, 1));
            key_in    = b;
            checks++;
            if (key_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL ignore_ready%0d: got key_ready=%b busy=%b expected 0 1",
                         e, key_ready, busy);
            end
            @(posedge clk);
            @(negedge clk);
        end
        key_valid = 1'b0;
        checks++;
        if (keys_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_done: got keys_ready=%b expected 1", keys_ready);
        end
        for (int r = 0; r <= 10; r++) begin
            do_read(4'(r));
            checks++;
            if (rv !== 1'b1 || rk !== exp_rk[r]) begin
                errors++;
                $display("FAIL ignore_slot%0d: got v=%b %h expected 1 %h", r, rv, rk, exp_rk[r]);
            end
        end
        for (int i = 11; i <= 15; i += 4) begin
            do_read(4'(i));
            checks++;
            if (rv !== 1'b0 || rk !== '0) begin
                errors++;
                $display("FAIL read_idx%0d: got v=%b %h expected 0 0", i, rv, rk);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [127:0] k;
        int n;
        k = {$urandom, $urandom, $urandom, $urandom};
        load_key(k);
        repeat (4) do_read(4'd0);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({key_ready, busy, keys_ready, rd_valid} !== 4'b1000 || rd_key !== '0) begin
            errors++;
            $display("FAIL async_reset: got rdy/busy/kr/rv=%b key=%h expected 1000 key=0",
                     {key_ready, busy, keys_ready, rd_valid}, rd_key);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(4'd0);
        checks++;
        if (rv !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_read: got valid=%b expected 0", rv);
        end
        k = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k);
        load_key(k);
        wait_ready(n);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL async_latency: got %0d edges expected 10", n);
        end
        for (int r = 0; r <= 10; r++) begin
            do_read(4'(r));
            checks++;
            if (rv !== 1'b1 || rk !== exp_rk[r]) begin
                errors++;
                $display("FAIL async_slot%0d: got v=%b %h expected 1 %h", r, rv, rk, exp_rk[r]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] k;
        int n;
        for (int t = 0; t < 3; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k);
            load_key(k);
            wait_ready(n);
            checks++;
            if (n !== 10) begin
                errors++;
                $display("FAIL b2b%0d_latency: got %0d edges expected 10", t, n);
            end
            for (int r = 0; r <= 10; r++) begin
                do_read(4'(r));
                checks++;
                if (rv !== 1'b1 || rk !== exp_rk[r]) begin
                    errors++;
                    $display("FAIL b2b%0d_slot%0d: got v=%b %h expected 1 %h", t, r, rv, rk, exp_rk[r]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_fips_key;
        test_rekey_zero;
        test_read_while_expanding;
        test_ignore_valid;
        test_async_reset;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
